// File: rtl/adc16dv160_pkg.sv
// Shared types and widths for the ADC16DV160 capture/packing path.
package adc16dv160_pkg;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_t;
endpackage

// File: rtl/adc16dv160_sfifo.sv
// First-word-fall-through sync FIFO with a registered output stage; the head
// entry stays counted in level until it is handshaken away.
module adc16dv160_sfifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     mark_last,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-2:0] data_mem [DEPTH];
  logic [DEPTH-1:0] last_bits;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_addr, last_addr;
  logic [AW:0]      count, avail;
  logic             pop, push, load, force_now;
  logic [WIDTH-2:0] out_data;
  logic             out_last, out_valid;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign level     = count;
  assign pop       = out_valid & rd_en;
  assign push      = wr_en & (!full | pop);
  assign rd_addr   = rd_ptr + AW'(pop);
  assign last_addr = wr_ptr - AW'(1);
  assign avail     = count - (AW+1)'(pop);
  assign load      = (!out_valid | pop) & (avail != '0);
  // A dropped final word moves the end-of-stream marker onto the newest stored entry.
  assign force_now = mark_last & !push & !empty;

  always_ff @(posedge clk) begin
    if (push) data_mem[wr_ptr] <= wr_data[WIDTH-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_bits <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        last_bits[wr_ptr] <= wr_data[WIDTH-1];
        wr_ptr            <= wr_ptr + AW'(1);
      end else if (force_now) begin
        last_bits[last_addr] <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (load) begin
        out_data  <= data_mem[rd_addr];
        out_last  <= last_bits[rd_addr] | (force_now & (rd_addr == last_addr));
        out_valid <= 1'b1;
      end else begin
        if (pop) out_valid <= 1'b0;
        if (force_now && out_valid && rd_ptr == last_addr) out_last <= 1'b1;
      end
    end
  end

  assign rd_data  = {out_last, out_data};
  assign rd_valid = out_valid;
endmodule

// File: rtl/adc16dv160_capture_packer.sv
// Captures dsize words of paired 16-bit samples (ADC or ramp) after a start pulse
// and streams them out through a FWFT buffer with tlast on the final word.
module adc16dv160_capture_packer
  import adc16dv160_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                adc_clk,
  input  logic                adc_rst,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                test,
  input  logic                start,
  input  logic [31:0]         dsize,
  output logic                busy,
  output logic                pc,
  output logic                overflow,
  output logic [WORD_W-1:0]   m_axis_tdata,
  output logic [3:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  cap_state_t          state;
  logic [SAMPLE_W-1:0] s_r, ramp, lo, sample;
  logic                test_r, half;
  logic [31:0]         word_cnt, word_cnt_max;
  logic                write_attempt, is_last_word, pop, drop, drain_done;
  logic                fifo_full, fifo_empty;
  logic [LW-1:0]       fifo_level;
  logic [WORD_W:0]     fifo_out;

  assign sample        = test_r ? ramp : s_r;
  assign write_attempt = (state == CAPTURE) & half;
  assign is_last_word  = (word_cnt == word_cnt_max - 32'd1);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign drop          = write_attempt & fifo_full & !pop;
  // Leave DRAIN on the edge that pops the last entry so pc rises with that handshake.
  assign drain_done    = fifo_empty | ((fifo_level == LW'(1)) & pop);

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state        <= IDLE;
      s_r          <= '0;
      test_r       <= 1'b0;
      ramp         <= '0;
      lo           <= '0;
      half         <= 1'b0;
      word_cnt     <= '0;
      word_cnt_max <= '0;
      pc           <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      s_r    <= adc_data;
      test_r <= test;
      case (state)
        IDLE: begin
          if (start) begin
            if (dsize != 32'd0) begin
              state        <= CAPTURE;
              word_cnt_max <= dsize;
              word_cnt     <= '0;
              half         <= 1'b0;
              pc           <= 1'b0;
              overflow     <= 1'b0;
              ramp         <= '0;
            end else begin
              pc <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          ramp <= ramp + 16'd1;
          half <= ~half;
          if (!half) begin
            lo <= sample;
          end else begin
            word_cnt <= word_cnt + 32'd1;
            if (drop) overflow <= 1'b1;
            if (is_last_word) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            pc    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  adc16dv160_sfifo #(
    .WIDTH(WORD_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (adc_clk),
    .rst      (adc_rst),
    .wr_en    (write_attempt),
    .wr_data  ({is_last_word, sample, lo}),
    .mark_last(drop & is_last_word),
    .rd_en    (m_axis_tready),
    .rd_data  (fifo_out),
    .rd_valid (m_axis_tvalid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign busy         = (state != IDLE);
  assign m_axis_tdata = fifo_out[WORD_W-1:0];
  assign m_axis_tlast = fifo_out[WORD_W];
  assign m_axis_tkeep = 4'hF;
endmodule
